// File: rtl/pattern_recorder_if.sv
// pattern_recorder_if: capture-side bus between input encoder,
// recorder and sequence control.
interface pattern_recorder_if #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2,
  parameter int IDX_W = 3
);
  logic                   start;
  logic                   mode;
  logic [WIDTH-1:0]       inData;
  logic                   inStrobe;
  logic [DEPTH*WIDTH-1:0] expData;
  logic [DEPTH*WIDTH-1:0] recData;
  logic [IDX_W-1:0]       index;
  logic                   busy;
  logic                   done;
  logic                   match;
  logic                   mismatch;

  modport master (
    output start, mode, inData,
    output inStrobe, expData,
    input  recData, index, busy,
    input  done, match, mismatch
  );

  modport slave (
    input  start, mode, inData,
    input  inStrobe, expData,
    output recData, index, busy,
    output done, match, mismatch
  );
endinterface

// File: rtl/pattern_recorder.sv
// pattern_recorder: records or checks a DEPTH-long
// sequence of WIDTH-bit symbols entered on strobe edges.
module pattern_recorder #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  pattern_recorder_if.slave  bus
);
  localparam int DW = DEPTH * WIDTH;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    rec_q, rec_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_q, match_d;
  logic             mism_q, mism_d;
  logic             mode_q, mode_d;
  logic             strb_q;
  logic             edge_w;
  logic [WIDTH-1:0] exp_sym;

  assign edge_w = bus.inStrobe & ~strb_q;

  // Expected symbol for the slot about to be compared.
  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == IDX_W'(i))
        exp_sym = bus.expData[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: start has priority; edges only count in CAPTURE.
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    idx_d   = idx_q;
    match_d = match_q;
    mism_d  = mism_q;
    mode_d  = mode_q;
    if (bus.start) begin
      mode_d  = bus.mode;
      idx_d   = '0;
      match_d = 1'b0;
      mism_d  = 1'b0;
      state_d = CAPTURE;
      if (!bus.mode)
        rec_d = '0;
    end else if (state_q == CAPTURE && edge_w) begin
      if (!mode_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (idx_q == IDX_W'(i))
            rec_d[i*WIDTH +: WIDTH] = bus.inData;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST)
          state_d = DONE;
      end else if (bus.inData == exp_sym) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          match_d = 1'b1;
          state_d = DONE;
        end
      end else begin
        mism_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rec_q   <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
      mism_q  <= 1'b0;
      mode_q  <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      mode_q  <= mode_d;
      strb_q  <= bus.inStrobe;
    end
  end

  assign bus.recData  = rec_q;
  assign bus.index    = idx_q;
  assign bus.busy     = (state_q == CAPTURE);
  assign bus.done     = (state_q == DONE);
  assign bus.match    = match_q;
  assign bus.mismatch = mism_q;
endmodule

// File: tb/tb_pattern_recorder.sv
// tb_pattern_recorder: directed stimulus, completion
// results checked by a scoreboard monitor.
module tb_pattern_recorder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pattern_recorder_if #(
    .DEPTH(5), .WIDTH(2), .IDX_W(3)
  ) bus ();

  pattern_recorder #(
    .DEPTH(5), .WIDTH(2), .IDX_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [9:0] rec;
    logic [2:0] idx;
    logic       m;
    logic       mm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic done_prev;

  localparam logic [9:0] SEQ = 10'b01_10_00_11_01;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [1:0] d);
    bus.inData   = d;
    bus.inStrobe = 1'b1;
    tick();
    bus.inStrobe = 1'b0;
    tick();
  endtask

  task automatic go(input logic m);
    bus.start = 1'b1;
    bus.mode  = m;
    tick();
    bus.start = 1'b0;
  endtask

  // Monitor: each rising done pops one expected result.
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got 1 want 0");
      end else begin
        e = q.pop_front();
        chk("sb_rec", 32'(bus.recData), 32'(e.rec));
        chk("sb_idx", 32'(bus.index), 32'(e.idx));
        chk("sb_match", 32'(bus.match), 32'(e.m));
        chk("sb_mism", 32'(bus.mismatch), 32'(e.mm));
      end
    end
    done_prev <= bus.done;
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.inData   = '0;
    bus.inStrobe = 1'b0;
    bus.expData  = SEQ;
    tick();
    tick();
    chk("rst_rec", 32'(bus.recData), 0);
    chk("rst_idx", 32'(bus.index), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_match", 32'(bus.match), 0);
    chk("rst_mism", 32'(bus.mismatch), 0);
    reset = 1'b0;
    tick();

    // Record 1,3,0,2,1.
    q.push_back('{SEQ, 3'd5, 1'b0, 1'b0});
    go(1'b0);
    chk("rec_busy", 32'(bus.busy), 1);
    enter(2'd1);
    enter(2'd3);
    enter(2'd0);
    enter(2'd2);
    enter(2'd1);
    chk("rec_busy_end", 32'(bus.busy), 0);
    chk("rec_done", 32'(bus.done), 1);
    enter(2'd2);
    chk("done_idx_hold", 32'(bus.index), 5);
    chk("done_rec_hold", 32'(bus.recData), 32'(SEQ));

    // Check mode, correct sequence.
    q.push_back('{SEQ, 3'd5, 1'b1, 1'b0});
    go(1'b1);
    enter(2'd1);
    enter(2'd3);
    enter(2'd0);
    enter(2'd2);
    enter(2'd1);

    // Check mode, 3rd entry wrong.
    q.push_back('{SEQ, 3'd2, 1'b0, 1'b1});
    go(1'b1);
    enter(2'd1);
    enter(2'd3);
    enter(2'd2);
    enter(2'd2);
    enter(2'd1);
    chk("mm_idx_hold", 32'(bus.index), 2);
    chk("mm_flag_hold", 32'(bus.mismatch), 1);
    chk("mm_no_match", 32'(bus.match), 0);

    // Restart from DONE after mismatch.
    go(1'b1);
    chk("rs_idx", 32'(bus.index), 0);
    chk("rs_mism", 32'(bus.mismatch), 0);
    chk("rs_done", 32'(bus.done), 0);
    chk("rs_busy", 32'(bus.busy), 1);
    q.push_back('{SEQ, 3'd5, 1'b1, 1'b0});
    enter(2'd1);
    enter(2'd3);
    enter(2'd0);
    enter(2'd2);
    enter(2'd1);

    // Held strobe counts once.
    go(1'b0);
    bus.inData   = 2'd3;
    bus.inStrobe = 1'b1;
    repeat (10) tick();
    bus.inStrobe = 1'b0;
    tick();
    chk("held_idx", 32'(bus.index), 1);
    chk("held_rec", 32'(bus.recData), 3);

    // start beats a same-cycle edge.
    bus.inData   = 2'd2;
    bus.inStrobe = 1'b1;
    bus.start    = 1'b1;
    bus.mode     = 1'b0;
    tick();
    bus.start    = 1'b0;
    chk("sw_idx", 32'(bus.index), 0);
    chk("sw_rec", 32'(bus.recData), 0);
    bus.inStrobe = 1'b0;
    tick();
    chk("sw_idx2", 32'(bus.index), 0);

    // Reset mid-capture, then edges in IDLE.
    go(1'b0);
    enter(2'd1);
    enter(2'd2);
    enter(2'd3);
    chk("mid_idx", 32'(bus.index), 3);
    chk("mid_rec", 32'(bus.recData), 32'h39);
    reset = 1'b1;
    tick();
    chk("mrst_rec", 32'(bus.recData), 0);
    chk("mrst_idx", 32'(bus.index), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    enter(2'd1);
    enter(2'd2);
    chk("idle_idx", 32'(bus.index), 0);
    chk("idle_busy", 32'(bus.busy), 0);

    repeat (3) tick();
    chk("sb_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_recorder.md
Name: pattern_recorder

Overview:
- Capture-side counterpart of the stage sequencer that replays five 2-bit symbols.
- Records a DEPTH-long sequence of WIDTH-bit symbols entered one per strobe (player/button input). The packed result drives the sequencer's per-stage data inputs.
- In check mode it compares each entered symbol against an expected packed sequence and reports match or mismatch, aborting on the first wrong symbol.
- Sits between the input debouncer/encoder and the game/sequence control logic.

Parameters:
- DEPTH, 5, number of symbols per sequence (2..7).
- WIDTH, 2, bits per symbol.
- IDX_W, 3, width of the slot index; must hold DEPTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request: begin or restart a capture.
- mode  input  1  0 = record, 1 = check; sampled only on a cycle where start is accepted.
- inData  input  WIDTH  symbol entered by the user.
- inStrobe  input  1  level from the input stage; each 0→1 transition is one entry.
- expData  input  DEPTH*WIDTH  expected sequence, slot 0 in bits [WIDTH-1:0].
- recData  output  DEPTH*WIDTH  recorded sequence, slot 0 in LSBs.
- index  output  IDX_W  number of symbols accepted so far in the current capture.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.
- match  output  1  check mode finished with all slots equal.
- mismatch  output  1  check mode hit an unequal symbol.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - State is IDLE.
  - recData, index, busy, done, match and mismatch are all 0.
  - The latched mode is 0 and the strobe history register is 0.
- Edge detect:
  - An entry is an edge when inStrobe=1 this cycle and the history register is 0.
  - The history register loads inStrobe every cycle in every state.
  - A strobe held high is one entry only.
  - After reset, a strobe already high produces one edge. It is ignored unless state is CAPTURE.
- States:
  - IDLE: start → CAPTURE. Edges are ignored.
  - CAPTURE (busy=1): edges are processed as described below.
  - DONE (done=1): all outputs hold. Edges are ignored. start → CAPTURE.
- Accepting start (any non-reset state):
  - Latch mode, index←0, done/match/mismatch←0, state←CAPTURE.
  - In record mode also clear recData to 0. In check mode recData holds.
- start in CAPTURE restarts the capture: index←0, with the same clears as above.
- start and an edge in the same cycle: start wins and the edge is discarded.
- Edge in CAPTURE, record mode:
  - Slot[index] ← inData and index ← index+1, both visible the cycle after the edge cycle.
  - If index was DEPTH-1, go to DONE in the same clock. done is visible the same cycle as the final slot value.
- Edge in CAPTURE, check mode:
  - Compare inData with expData slot[index].
  - Equal: index+1. On the last slot, go to DONE with match←1.
  - Unequal: mismatch←1, go to DONE, and index stays at the failing slot number.
- Exclusivity: match and mismatch are never both 1.
- Index range: index never exceeds DEPTH and never wraps within a capture.
- expData change: a change mid-capture affects only slots not yet compared.
- Reset in any state, including mid-capture, returns to the reset values above.
- Latency: one clock from the strobe edge cycle to updated outputs. No combinational path from inputs to outputs.

Test Plan:
- Reset then start(mode=0), strobes with inData 1,3,0,2,1 → recData=10'b01_10_00_11_01; index=5; done=1 on the cycle after the 5th edge; busy=0.
- start(mode=1) with expData=10'b01_10_00_11_01 and the same 5 entries → match=1, mismatch=0, index=5.
- Check mode with the 3rd entry 2 instead of 0 → mismatch=1 one cycle after the 3rd edge; index=2; later strobes ignored; match=0.
- inStrobe held high 10 cycles with one 0→1 edge → index increments by exactly 1. start in the same cycle as an edge → index=0 and the entry is dropped.
- Reset asserted after 3 recorded entries → next cycle recData=0, index=0, state IDLE. Edges in IDLE leave index=0.
- start while in DONE after a mismatch → flags cleared, index=0; a full correct re-entry yields match=1.
